// File: rtl/dcache_2way_if.sv
// CPU-side and memory-side bus of the 2-way data cache.
// slave  = cache side, master = CPU/memory environment side.
interface dcache_2way_if #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
);
    localparam int LINE_W = 8 * (2 ** OFFSET_W);

    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back, write-allocate data cache.
// Hits complete combinationally in IDLE; misses run WRITEBACK (dirty
// victim only) -> FILL -> FILLDONE, then the held request hits.
// Optional statistics counters: define DCACHE_STATS_EN.
module dcache_2way #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_2way_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o,
    output logic [31:0]   wb_cnt_o
`endif
);
    localparam int LINE_W = 8 * (2 ** OFFSET_W);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS   = 2 ** INDEX_W;
    localparam int WORD_W = OFFSET_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, FILLDONE} state_t;

    state_t r_state, w_next;

    // Status bits are reset; tags and line data are not.
    logic [1:0][SETS-1:0] r_valid;
    logic [1:0][SETS-1:0] r_dirty;
    logic [SETS-1:0]      r_lru;     // names the least-recently-used way
    logic [TAG_W-1:0]     r_tag  [2][SETS];
    logic [LINE_W-1:0]    r_data [2][SETS];

    // Miss context, frozen when leaving IDLE so a dropped request
    // cannot disturb the refill.
    logic                 r_vway;
    logic [INDEX_W-1:0]   r_vidx;
    logic [TAG_W-1:0]     r_rtag;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [WORD_W-1:0]    w_word;
    logic [WORD_W+4:0]    w_bit;
    logic                 w_req, w_wr;
    logic [1:0]           w_match;
    logic                 w_hit, w_hway;
    logic                 w_vway, w_vdirty, w_miss;
    logic [LINE_W-1:0]    w_hline;
    logic                 w_mem_en, w_mem_wr;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic                 w_unused_addr;

    assign w_tag  = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx  = bus.p1_addr_i[OFFSET_W +: INDEX_W];
    assign w_word = bus.p1_addr_i[2 +: WORD_W];
    assign w_bit  = {w_word, 5'b0};
    assign w_unused_addr = &{1'b0, bus.p1_addr_i[1:0]};

    // Read+write together counts as a write.
    assign w_req = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign w_wr  = bus.p1_MemWrite_i;

    assign w_match[0] = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_match[1] = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hway     = w_match[1];
    // Hits are only honoured in IDLE, so FILLDONE still stalls.
    assign w_hit      = w_req && (r_state == IDLE) && (|w_match);
    assign w_miss     = w_req && (r_state == IDLE) && !(|w_match);

    assign w_hline        = r_data[w_hway][w_idx];
    assign bus.p1_data_o  = w_hline[w_bit +: 32];
    assign bus.p1_stall_o = w_req & ~w_hit;

    // Victim: first invalid way, otherwise the LRU way.
    assign w_vway   = !r_valid[0][w_idx] ? 1'b0 :
                      !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_vdirty = r_valid[w_vway][w_idx] & r_dirty[w_vway][w_idx];

    assign bus.mem_enable_o = w_mem_en;
    assign bus.mem_write_o  = w_mem_wr;
    assign bus.mem_addr_o   = w_mem_addr;
    assign bus.mem_data_o   = r_data[r_vway][r_vidx];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and memory-side outputs.
    always_comb begin
        w_next     = r_state;
        w_mem_en   = 1'b0;
        w_mem_wr   = 1'b0;
        w_mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (w_miss) w_next = w_vdirty ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                w_mem_en   = 1'b1;
                w_mem_wr   = 1'b1;
                w_mem_addr = {r_tag[r_vway][r_vidx], r_vidx, {OFFSET_W{1'b0}}};
                if (bus.mem_ack_i) w_next = FILL;
            end
            FILL: begin
                w_mem_en   = 1'b1;
                w_mem_addr = {r_rtag, r_vidx, {OFFSET_W{1'b0}}};
                if (bus.mem_ack_i) w_next = FILLDONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status bits, LRU and miss context.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_lru   <= '0;
            r_vway  <= 1'b0;
            r_vidx  <= '0;
            r_rtag  <= '0;
        end else begin
            if (w_miss) begin
                r_vway <= w_vway;
                r_vidx <= w_idx;
                r_rtag <= w_tag;
            end
            if (w_hit) begin
                r_lru[w_idx] <= ~w_hway;
                if (w_wr) r_dirty[w_hway][w_idx] <= 1'b1;
            end
            if (r_state == FILL && bus.mem_ack_i) begin
                r_valid[r_vway][r_vidx] <= 1'b1;
                r_dirty[r_vway][r_vidx] <= 1'b0;
            end
        end
    end

    // Line data and tags: write-hit word update and refill.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_hit && w_wr)
                r_data[w_hway][w_idx][w_bit +: 32] <= bus.p1_data_i;
            if (r_state == FILL && bus.mem_ack_i) begin
                r_data[r_vway][r_vidx] <= bus.mem_data_i;
                r_tag[r_vway][r_vidx]  <= r_rtag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit cycles, miss starts and write-back entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
        end else begin
            if (w_hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (w_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
            if (r_state == IDLE && w_next == WRITEBACK) wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule
